mtimer: RTL and testbench
=========================

Name: mtimer

Overview:
- Memory-mapped machine timer and software-interrupt source. It generates the `m_timer` and `m_software` interrupt lines that the CSR file's `mip` sees on bits 7 and 3.
- It sits on the core's data bus as a slave. It holds a free-running 64-bit `mtime`, a 64-bit `mtimecmp` and an `msip` bit.
- It is the transmitting end of the interrupt interface that the trap/CSR logic receives.

Parameters:
- `PRESCALE`, default 1, core-clock cycles per `mtime` increment; legal range 1..65535.
- `BASE_ADDR`, default 32'h0200_0000, bus base address; only `addr_i[4:0]` is decoded.

Ports:
- `clk_i`  in  1  core clock
- `rst_i`  in  1  asynchronous reset, active-high
- `req_i`  in  1  bus request, valid for one cycle
- `we_i`  in  1  1 = write, 0 = read
- `addr_i`  in  32  byte address
- `be_i`  in  4  byte enables for writes
- `wdata_i`  in  32  write data
- `gnt_o`  out  1  grant; tied to 1, every request is accepted
- `rvalid_o`  out  1  response valid, one cycle after `req_i`
- `rdata_o`  out  32  read data, valid with `rvalid_o`
- `err_o`  out  1  access error, valid with `rvalid_o`
- `irqs_o`  out  `irqs_t`  {`m_software`, `m_timer`, `m_external`=0}

Behaviour:
- Reset (async, active-high): `mtime`=0, `mtimecmp`=64'hFFFF_FFFF_FFFF_FFFF, `msip`=0, prescaler count=0, `rvalid_o`=0, `rdata_o`=0, `err_o`=0, `irqs_o`=0. Reset mid-transaction drops the pending response; no `rvalid_o` follows.
- Register map (offset from `BASE_ADDR`):
  - 0x00 MTIME_LO
  - 0x04 MTIME_HI
  - 0x08 MTIMECMP_LO
  - 0x0C MTIMECMP_HI
  - 0x10 MSIP: bit 0 is R/W, bits 31:1 read 0, writes ignored
- Handshake:
  - `gnt_o`=1 always.
  - Every accepted `req_i` produces exactly one `rvalid_o` pulse the next cycle, for reads and writes.
  - Back-to-back requests give back-to-back responses.
  - Writes take effect at the clock edge that accepts them.
  - Reads return the value before any same-cycle update.
- Errors:
  - An unmapped offset (≥0x14) or `addr_i[1:0]`≠0 gives `err_o`=1 with `rvalid_o`, `rdata_o`=0, and the write is ignored.
  - `addr_i[31:5]` ≠ `BASE_ADDR[31:5]` is treated as unmapped.
- Writes obey `be_i` per byte. `be_i`=0 is a legal no-op write.
- Prescaler:
  - A counter counts 0..`PRESCALE`-1 and emits `tick` when it equals `PRESCALE`-1, then wraps to 0.
  - With `PRESCALE`=1, `tick` is asserted every cycle.
- `mtime` increments by 1 on `tick`. It wraps from 2^64-1 to 0 with no flag.
- Simultaneous write to MTIME_LO/HI and `tick`: the write wins for the written bytes and no increment is applied that cycle, including the carry into the unwritten half.
- Timer interrupt:
  - `irqs_o.m_timer` is registered as (`mtime_q` ≥ `mtimecmp_q`), unsigned 64-bit compare.
  - It asserts one cycle after the condition holds.
  - It is level-sensitive: it stays high until `mtimecmp` is raised above `mtime` or `mtime` is rewritten below it.
  - A write that clears the condition drops the interrupt one cycle after the write edge.
- Software interrupt: `irqs_o.m_software` = `msip` register, registered, visible the cycle after the write.
- `irqs_o.m_external` is tied to 0.

Optional Feature:
- Macro: `YARC_MTIMER_HI_LATCH_EN`.
- Defined:
  - A read of MTIME_LO snapshots `mtime[63:32]` into a shadow register in the same cycle.
  - A following MTIME_HI read returns the shadow, giving a tear-free 64-bit read when LO is read first.
  - The shadow resets to 0 and is also updated by writes to MTIME_HI.
- Not defined: MTIME_HI reads return live `mtime[63:32]`, and no shadow register exists.

Decomposition:
- New `mtimer_pkg` holds:
  - register offset constants `MTIMER_MTIME_LO`/`_HI`, `MTIMER_MTIMECMP_LO`/`_HI`, `MTIMER_MSIP`;
  - `MTIMER_MAP_SIZE` = 5'h14.
- `irqs_t` is reused from `csr_pkg`.
- Sub-module `mtimer_prescaler` (counter plus `tick` output) is parameterised by `PRESCALE`.

Test Plan:
- Reset, then read 0x08 and 0x0C: both return 32'hFFFF_FFFF; `irqs_o`=3'b000; MTIME_LO read after 10 cycles with `PRESCALE`=1 returns 10 (±1 for read timing, checked exactly against the model).
- Write MTIMECMP_HI=0, MTIMECMP_LO=20: `m_timer` rises exactly one cycle after `mtime` reaches 20. Then write MTIMECMP_LO=1000: `m_timer` falls one cycle later.
- Write MTIME_LO=32'hFFFF_FFFF with `PRESCALE`=1: next tick makes MTIME_HI=1 and MTIME_LO=0. A write of MTIME_LO in the same cycle as a tick gives exactly the written value.
- Write MSIP=32'hFFFF_FFFF: readback is 1 and `m_software`=1 next cycle. Write 0: `m_software`=0 next cycle.
- Read offset 0x14 and write 0x02: each gives `err_o`=1, `rdata_o`=0, registers unchanged. A byte-enable write `be_i`=4'b0010 to MTIMECMP_LO changes only bits 15:8.
- With `PRESCALE`=4: `mtime` advances once per 4 cycles. With `YARC_MTIMER_HI_LATCH_EN`, set `mtime`=32'hFFFF_FFFE (HI=0), read LO, wait 8 cycles, read HI: returns 0, not 1.

Source files
------------

// File: rtl/csr_pkg.sv
// csr_pkg: types shared between the CSR file and the interrupt sources that feed mip.
package csr_pkg;

    // Machine-level interrupt lines, in mip bit order (MSIP=3, MTIP=7, MEIP=11).
    typedef struct packed {
        logic m_software;
        logic m_timer;
        logic m_external;
    } irqs_t;

endpackage

// File: rtl/mtimer_pkg.sv
// mtimer_pkg: register map of the machine timer and a byte-enable merge helper.
package mtimer_pkg;

    localparam logic [4:0] MTIMER_MTIME_LO    = 5'h00;
    localparam logic [4:0] MTIMER_MTIME_HI    = 5'h04;
    localparam logic [4:0] MTIMER_MTIMECMP_LO = 5'h08;
    localparam logic [4:0] MTIMER_MTIMECMP_HI = 5'h0C;
    localparam logic [4:0] MTIMER_MSIP        = 5'h10;
    localparam logic [4:0] MTIMER_MAP_SIZE    = 5'h14;

    // Replace the bytes of old_val selected by be with the matching bytes of wdata.
    function automatic logic [31:0] mtimer_be_merge(input logic [31:0] old_val,
                                                    input logic [31:0] wdata,
                                                    input logic [3:0]  be);
        logic [31:0] merged;
        merged = old_val;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                merged[8*b +: 8] = wdata[8*b +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/mtimer_prescaler.sv
// mtimer_prescaler: divides the core clock, pulsing tick once every PRESCALE cycles.
module mtimer_prescaler #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam logic [15:0] LAST_COUNT = 16'(PRESCALE - 1);

    logic [15:0] count_q;

    assign tick = (count_q == LAST_COUNT);

    // Count 0..PRESCALE-1 and wrap on the tick cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (tick) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + 16'd1;
        end
    end

endmodule

// File: rtl/mtimer.sv
// mtimer: memory-mapped mtime/mtimecmp/msip block driving the machine timer and
// software interrupt lines. Optional macro YARC_MTIMER_HI_LATCH_EN adds a shadow of
// mtime[63:32] captured on MTIME_LO reads so a LO-then-HI read pair is tear-free.
module mtimer
    import mtimer_pkg::*;
    import csr_pkg::*;
#(
    parameter int unsigned PRESCALE  = 1,
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic        gnt_o,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output irqs_t       irqs_o
);

    logic        tick;
    logic [63:0] mtime_q;
    logic [63:0] mtimecmp_q;
    logic        msip_q;
    logic        m_timer_q;
    logic [63:0] mtime_d;
    logic [63:0] mtimecmp_d;
    logic        msip_d;
    logic        mtime_written;
    logic [31:0] rdata_mux;
    logic [4:0]  offset;
    logic        addr_ok;
    logic        rd_en;
    logic        wr_en;
    logic        rvalid_q;
    logic        err_q;
    logic [31:0] rdata_q;
`ifdef YARC_MTIMER_HI_LATCH_EN
    logic [31:0] mtime_hi_shadow_q;
`endif

    mtimer_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk  (clk_i),
        .rst  (rst_i),
        .tick (tick)
    );

    // Only the low five address bits select a register; a foreign window or a
    // misaligned or out-of-range offset is an error and has no side effects.
    assign offset  = addr_i[4:0];
    assign addr_ok = (addr_i[31:5] == BASE_ADDR[31:5]) && (addr_i[1:0] == 2'b00) &&
                     (offset < MTIMER_MAP_SIZE);
    assign rd_en   = req_i && !we_i && addr_ok;
    assign wr_en   = req_i && we_i && addr_ok;

    // Read mux over the current register values, i.e. before any same-cycle update.
    always_comb begin
        rdata_mux = '0;
        case (offset)
            MTIMER_MTIME_LO:    rdata_mux = mtime_q[31:0];
`ifdef YARC_MTIMER_HI_LATCH_EN
            MTIMER_MTIME_HI:    rdata_mux = mtime_hi_shadow_q;
`else
            MTIMER_MTIME_HI:    rdata_mux = mtime_q[63:32];
`endif
            MTIMER_MTIMECMP_LO: rdata_mux = mtimecmp_q[31:0];
            MTIMER_MTIMECMP_HI: rdata_mux = mtimecmp_q[63:32];
            MTIMER_MSIP:        rdata_mux = {31'b0, msip_q};
            default:            rdata_mux = '0;
        endcase
    end

    // Next register values: bus writes win, and any written mtime byte suppresses
    // the tick increment for the whole 64-bit counter that cycle.
    always_comb begin
        mtime_d       = mtime_q;
        mtimecmp_d    = mtimecmp_q;
        msip_d        = msip_q;
        mtime_written = 1'b0;
        if (wr_en) begin
            case (offset)
                MTIMER_MTIME_LO: begin
                    mtime_d[31:0] = mtimer_be_merge(mtime_q[31:0], wdata_i, be_i);
                    mtime_written = |be_i;
                end
                MTIMER_MTIME_HI: begin
                    mtime_d[63:32] = mtimer_be_merge(mtime_q[63:32], wdata_i, be_i);
                    mtime_written  = |be_i;
                end
                MTIMER_MTIMECMP_LO: mtimecmp_d[31:0]  = mtimer_be_merge(mtimecmp_q[31:0], wdata_i, be_i);
                MTIMER_MTIMECMP_HI: mtimecmp_d[63:32] = mtimer_be_merge(mtimecmp_q[63:32], wdata_i, be_i);
                MTIMER_MSIP: begin
                    if (be_i[0]) begin
                        msip_d = wdata_i[0];
                    end
                end
                default: ;
            endcase
        end
        if (tick && !mtime_written) begin
            mtime_d = mtime_q + 64'd1;
        end
    end

    // Architectural timer state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            msip_q     <= 1'b0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            msip_q     <= msip_d;
        end
    end

    // One response per accepted request, exactly one cycle later.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= req_i;
            err_q    <= req_i && !addr_ok;
            rdata_q  <= rd_en ? rdata_mux : 32'h0;
        end
    end

    // Timer interrupt is a registered level of the unsigned 64-bit compare.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            m_timer_q <= 1'b0;
        end else begin
            m_timer_q <= (mtime_q >= mtimecmp_q);
        end
    end

`ifdef YARC_MTIMER_HI_LATCH_EN
    // Snapshot the upper half on a LO read; a HI write keeps the shadow coherent.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mtime_hi_shadow_q <= '0;
        end else if (rd_en && (offset == MTIMER_MTIME_LO)) begin
            mtime_hi_shadow_q <= mtime_q[63:32];
        end else if (wr_en && (offset == MTIMER_MTIME_HI)) begin
            mtime_hi_shadow_q <= mtimer_be_merge(mtime_q[63:32], wdata_i, be_i);
        end
    end
`endif

    assign gnt_o    = 1'b1;
    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;
    assign err_o    = err_q;
    assign irqs_o   = '{m_software: msip_q, m_timer: m_timer_q, m_external: 1'b0};

endmodule

// File: tb/tb_mtimer.sv
// tb_mtimer: scoreboard bench for mtimer. Two instances (PRESCALE=1 and 4) share one
// bus; a reference model predicts every response and irq level from the register rules.
module tb_mtimer;
    import csr_pkg::*;

    localparam logic [31:0] BASE = 32'h0200_0000;

    typedef struct {
        bit          is_read;
        logic        err;
        logic [31:0] rdata;
    } resp_t;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_i = 1'b0;
    logic        we_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic [3:0]  be_i = '0;
    logic [31:0] wdata_i = '0;

    logic        gnt0, rvalid0, err0, gnt1, rvalid1, err1;
    logic [31:0] rdata0, rdata1;
    irqs_t       irqs0, irqs1;

    int errors = 0;
    int checks = 0;

    resp_t       q0[$];
    resp_t       q1[$];
    logic [63:0] m_mtime[2];
    logic [63:0] m_cmp[2];
    logic        m_msip[2];
    logic [31:0] m_shadow[2];
    int          m_cnt[2];
    logic [2:0]  exp_irq[2];

    mtimer #(.PRESCALE(1), .BASE_ADDR(BASE)) dut0 (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
        .be_i(be_i), .wdata_i(wdata_i), .gnt_o(gnt0), .rvalid_o(rvalid0),
        .rdata_o(rdata0), .err_o(err0), .irqs_o(irqs0));

    mtimer #(.PRESCALE(4), .BASE_ADDR(BASE)) dut1 (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
        .be_i(be_i), .wdata_i(wdata_i), .gnt_o(gnt1), .rvalid_o(rvalid1),
        .rdata_o(rdata1), .err_o(err1), .irqs_o(irqs1));

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] merge(input logic [31:0] old_val, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) res[8*b +: 8] = be[b] ? wd[8*b +: 8] : old_val[8*b +: 8];
        return res;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: mtime advances when the cycle count since reset completes a
    // PRESCALE period; written mtime bytes replace the count and cancel that increment.
    always @(posedge clk_i or posedge rst_i) begin : model
        logic [63:0] t_pre, c_pre;
        logic [31:0] nv;
        logic [4:0]  off;
        bit          tick, written, ok;
        int          p;
        resp_t       r;
        if (rst_i) begin
            for (int i = 0; i < 2; i++) begin
                m_mtime[i] = '0; m_cmp[i] = '1; m_msip[i] = 1'b0;
                m_shadow[i] = '0; m_cnt[i] = 0; exp_irq[i] = 3'b000;
            end
            q0.delete();
            q1.delete();
        end else begin
            for (int i = 0; i < 2; i++) begin
                p       = (i == 0) ? 1 : 4;
                t_pre   = m_mtime[i];
                c_pre   = m_cmp[i];
                tick    = (m_cnt[i] % p) == (p - 1);
                m_cnt[i]++;
                written = 0;
                if (req_i) begin
                    off       = addr_i[4:0];
                    ok        = (addr_i[31:5] == BASE[31:5]) && (addr_i[1:0] == 2'b00) && (off < 5'h14);
                    r.is_read = !we_i;
                    r.err     = !ok;
                    r.rdata   = '0;
                    if (ok && !we_i) begin
                        case (off)
                            5'h00: begin
                                r.rdata = t_pre[31:0];
`ifdef YARC_MTIMER_HI_LATCH_EN
                                m_shadow[i] = t_pre[63:32];
`endif
                            end
`ifdef YARC_MTIMER_HI_LATCH_EN
                            5'h04: r.rdata = m_shadow[i];
`else
                            5'h04: r.rdata = t_pre[63:32];
`endif
                            5'h08: r.rdata = c_pre[31:0];
                            5'h0C: r.rdata = c_pre[63:32];
                            5'h10: r.rdata = {31'b0, m_msip[i]};
                            default: ;
                        endcase
                    end
                    if (ok && we_i) begin
                        case (off)
                            5'h00: begin
                                m_mtime[i][31:0] = merge(t_pre[31:0], wdata_i, be_i);
                                written = (be_i != 4'b0);
                            end
                            5'h04: begin
                                nv = merge(t_pre[63:32], wdata_i, be_i);
                                m_mtime[i][63:32] = nv;
                                written = (be_i != 4'b0);
`ifdef YARC_MTIMER_HI_LATCH_EN
                                m_shadow[i] = nv;
`endif
                            end
                            5'h08: m_cmp[i][31:0]  = merge(c_pre[31:0], wdata_i, be_i);
                            5'h0C: m_cmp[i][63:32] = merge(c_pre[63:32], wdata_i, be_i);
                            5'h10: if (be_i[0]) m_msip[i] = wdata_i[0];
                            default: ;
                        endcase
                    end
                    if (i == 0) q0.push_back(r);
                    else        q1.push_back(r);
                end
                if (tick && !written) m_mtime[i] = t_pre + 64'd1;
                exp_irq[i] = {m_msip[i], (t_pre >= c_pre), 1'b0};
            end
        end
    end

    // Monitor: on the falling edge match each DUT response against the scoreboard.
    always @(negedge clk_i) begin : monitor
        resp_t r;
        if (rst_i) begin
            check_output("reset rvalid/err/rdata dut0", {rvalid0, err0, rdata0[29:0]}, 32'h0);
            check_output("reset rvalid/err/rdata dut1", {rvalid1, err1, rdata1[29:0]}, 32'h0);
            check_output("reset irqs dut0", 32'(irqs0), 32'h0);
            check_output("reset irqs dut1", 32'(irqs1), 32'h0);
        end else begin
            check_output("gnt", {30'b0, gnt1, gnt0}, 32'h3);
            if (rvalid0) begin
                if (q0.size() == 0) check_output("spurious rvalid dut0", 32'h1, 32'h0);
                else begin
                    r = q0.pop_front();
                    check_output("err dut0", 32'(err0), 32'(r.err));
                    if (r.is_read || r.err) check_output("rdata dut0", rdata0, r.rdata);
                end
            end else if (q0.size() != 0) begin
                check_output("missing rvalid dut0", 32'h0, 32'h1);
                void'(q0.pop_front());
            end
            if (rvalid1) begin
                if (q1.size() == 0) check_output("spurious rvalid dut1", 32'h1, 32'h0);
                else begin
                    r = q1.pop_front();
                    check_output("err dut1", 32'(err1), 32'(r.err));
                    if (r.is_read || r.err) check_output("rdata dut1", rdata1, r.rdata);
                end
            end else if (q1.size() != 0) begin
                check_output("missing rvalid dut1", 32'h0, 32'h1);
                void'(q1.pop_front());
            end
            check_output("irqs dut0", 32'(irqs0), 32'(exp_irq[0]));
            check_output("irqs dut1", 32'(irqs1), 32'(exp_irq[1]));
        end
    end

    task automatic apply_stimulus(input logic we, input logic [31:0] offs, input logic [3:0] be,
                                  input logic [31:0] wd);
        @(posedge clk_i);
        #2;
        req_i = 1'b1; we_i = we; addr_i = BASE + offs; be_i = be; wdata_i = wd;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #2;
            req_i = 1'b0; we_i = 1'b0; be_i = '0; wdata_i = '0;
        end
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin : stimulus
        logic [31:0] offs_tab [8];
        offs_tab = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h02, 32'h0100_0000};
        repeat (2) @(posedge clk_i);
        #2 rst_i = 1'b0;

        // Reset values and free-running count.
        apply_stimulus(0, 32'h08, 4'h0, 0);
        apply_stimulus(0, 32'h0C, 4'h0, 0);
        idle(10);
        apply_stimulus(0, 32'h00, 4'h0, 0);

        // Timer compare: rise at 20, fall after raising the compare value.
        apply_stimulus(1, 32'h0C, 4'hF, 32'h0);
        apply_stimulus(1, 32'h08, 4'hF, 32'd20);
        idle(12);
        apply_stimulus(1, 32'h08, 4'hF, 32'd1000);
        idle(3);

        // Low-word carry and write-versus-tick.
        apply_stimulus(1, 32'h00, 4'hF, 32'hFFFF_FFFF);
        apply_stimulus(0, 32'h00, 4'h0, 0);
        apply_stimulus(0, 32'h04, 4'h0, 0);
        apply_stimulus(1, 32'h00, 4'hF, 32'h1234_5678);
        apply_stimulus(0, 32'h00, 4'h0, 0);
        idle(2);

        // Software interrupt set and clear.
        apply_stimulus(1, 32'h10, 4'hF, 32'hFFFF_FFFF);
        apply_stimulus(0, 32'h10, 4'h0, 0);
        apply_stimulus(1, 32'h10, 4'hF, 32'h0);
        idle(2);

        // Errors, partial byte enable, no-op write.
        apply_stimulus(0, 32'h14, 4'h0, 0);
        apply_stimulus(1, 32'h02, 4'hF, 32'hDEAD_BEEF);
        apply_stimulus(1, 32'h08, 4'b0010, 32'hAAAA_5A55);
        apply_stimulus(1, 32'h0C, 4'h0, 32'h1111_1111);
        apply_stimulus(0, 32'h08, 4'h0, 0);
        apply_stimulus(0, 32'h0C, 4'h0, 0);
        idle(8);
        apply_stimulus(0, 32'h00, 4'h0, 0);

        // Tear-free read sequence across a low-word wrap.
        apply_stimulus(1, 32'h04, 4'hF, 32'h0);
        apply_stimulus(1, 32'h00, 4'hF, 32'hFFFF_FFFE);
        apply_stimulus(0, 32'h00, 4'h0, 0);
        idle(8);
        apply_stimulus(0, 32'h04, 4'h0, 0);
        idle(2);

        // Reset while a request is in flight: its response must be dropped.
        apply_stimulus(0, 32'h08, 4'h0, 0);
        #1 rst_i = 1'b1;
        @(posedge clk_i);
        #2 rst_i = 1'b0; req_i = 1'b0;
        idle(2);
        apply_stimulus(0, 32'h0C, 4'h0, 0);

        // Randomised traffic.
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            apply_stimulus(1'($urandom_range(0, 1)), offs_tab[$urandom_range(0, 7)],
                           4'($urandom_range(0, 15)), $urandom);
        end
        idle(4);

        check_output("final queue dut0", 32'(q0.size()), 32'h0);
        check_output("final queue dut1", 32'(q1.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
